// File: rtl/sram_responder.sv
// On-chip stand-in for the CPU's SRAM: decodes the active-low strobe bus into
// multi-cycle reads/writes with configurable wait states, byte lanes and a preload port.
module sram_responder #(
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 1,
  parameter int WRITE_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_CE,
  input  logic              Mem_UB,
  input  logic              Mem_LB,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       Data_in,
  output logic [15:0]       Data_out,
  output logic              Data_valid,
  output logic              Busy,
  input  logic              Init_WE,
  input  logic [ADDR_W-1:0] Init_Addr,
  input  logic [15:0]       Init_Data,
  output logic [2:0]        dbg_state
);

  // Handshake: the strobes are level-sampled on every rising Clk edge; a request
  // stays valid only while its strobes stay asserted, and Data_valid is the
  // single-cycle completion marker for a read (no ready/back-pressure exists).
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_DONE = 3'd2,
    RD_HOLD = 3'd3,
    WR_WAIT = 3'd4,
    WR_HOLD = 3'd5
  } state_t;

  localparam logic [2:0] RD_LOAD = 3'(READ_LAT - 1);
  localparam logic [2:0] WR_LOAD = 3'(WRITE_LAT - 1);

  state_t            state, next_state;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              ub_q, lb_q;
  logic [15:0]       data_q;
  logic [15:0]       mem [2**ADDR_W];
  logic [15:0]       rd_word;
  logic              wr_req, rd_req;
  logic              unused_addr;

  assign wr_req      = !Mem_CE && !Mem_WE;
  assign rd_req      = !Mem_CE && !Mem_OE && Mem_WE;
  assign unused_addr = ^ADDR[15:ADDR_W];
  assign rd_word     = mem[addr_q];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (wr_req) next_state = WR_WAIT;
               else if (rd_req) next_state = RD_WAIT;
      RD_WAIT: if (!rd_req) next_state = IDLE;
               else if (cnt == 3'd0) next_state = RD_DONE;
      RD_DONE: next_state = rd_req ? RD_HOLD : IDLE;
      RD_HOLD: if (!rd_req) next_state = IDLE;
      WR_WAIT: if (!wr_req) next_state = IDLE;
               else if (cnt == 3'd0) next_state = WR_HOLD;
      WR_HOLD: if (!wr_req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    Busy       = (state != IDLE);
    Data_valid = (state == RD_DONE);
    dbg_state  = state;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt      <= 3'd0;
      addr_q   <= '0;
      ub_q     <= 1'b1;
      lb_q     <= 1'b1;
      data_q   <= 16'h0000;
      Data_out <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (wr_req || rd_req) begin
            addr_q <= ADDR[ADDR_W-1:0];
            ub_q   <= Mem_UB;
            lb_q   <= Mem_LB;
            cnt    <= wr_req ? WR_LOAD : RD_LOAD;
          end
          if (wr_req) data_q <= Data_in;
        end
        RD_WAIT: if (rd_req) begin
          if (cnt == 3'd0)
            Data_out <= {ub_q ? 8'h00 : rd_word[15:8], lb_q ? 8'h00 : rd_word[7:0]};
          else
            cnt <= cnt - 3'd1;
        end
        WR_WAIT: if (wr_req && cnt != 3'd0) cnt <= cnt - 3'd1;
        default: ;
      endcase
    end
  end

  // Array is never reset; Reset only gates the preload so a held reset cannot write.
  always_ff @(posedge Clk) begin
    if (state == WR_WAIT && wr_req && cnt == 3'd0) begin
      if (!ub_q) mem[addr_q][15:8] <= data_q[15:8];
      if (!lb_q) mem[addr_q][7:0]  <= data_q[7:0];
    end else if (state == IDLE && !wr_req && !rd_req && Init_WE && !Reset) begin
      mem[Init_Addr] <= Init_Data;
    end
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the CPU's asynchronous-style SRAM strobe interface (Mem_CE/UB/LB/OE/WE, all active-low) driven by the control unit.
- Services multi-cycle reads and writes against an internal word array, with configurable wait states and byte-lane masking.
- Provides a preload port so programs can be loaded while the CPU is halted.
- Replaces the external SRAM for simulation and on-chip builds.

Parameters:
- ADDR_W, 10, number of address bits used; array depth is 2^ADDR_W words of 16 bits.
- READ_LAT, 1, cycles from first sampled read strobe to Data_out valid (1..7).
- WRITE_LAT, 1, cycles WE must be sampled low before the write commits (1..7).

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Mem_CE  in  1  chip enable, active-low.
- Mem_UB  in  1  upper byte enable [15:8], active-low.
- Mem_LB  in  1  lower byte enable [7:0], active-low.
- Mem_OE  in  1  output enable (read strobe), active-low.
- Mem_WE  in  1  write enable, active-low.
- ADDR  in  16  word address; only ADDR[ADDR_W-1:0] is used.
- Data_in  in  16  write data from MDR.
- Data_out  out  16  registered read data.
- Data_valid  out  1  one-cycle pulse when a read completes.
- Busy  out  1  high in any state other than IDLE.
- Init_WE  in  1  preload write strobe, active-high.
- Init_Addr  in  ADDR_W  preload address.
- Init_Data  in  16  preload data.

Behaviour:
- Reset:
  - State goes to IDLE.
  - Data_out=16'h0000, Data_valid=0, Busy=0, wait counter=0.
  - Array contents are not cleared; reset mid-operation aborts the access with no commit.
- Strobe decode, sampled each edge:
  - Access: CE=0.
  - Write request: WE=0. WE has priority over OE.
  - Read request: OE=0 and WE=1.
- States: IDLE, RD_WAIT, RD_DONE, RD_HOLD, WR_WAIT, WR_HOLD.
- IDLE:
  - Read request: latch address and byte enables, load counter with READ_LAT-1, go to RD_WAIT.
  - Write request: latch address, byte enables and Data_in, load counter with WRITE_LAT-1, go to WR_WAIT.
  - Otherwise: if Init_WE=1, write Init_Data to Init_Addr (full word, no masking).
- RD_WAIT:
  - Counter decrements each cycle. At 0, Data_out <= array[latched addr], go to RD_DONE.
  - A disabled byte lane (UB=1 or LB=1 at latch) reads as 8'h00.
  - READ_LAT=1 means data is registered on the edge after the first sampled strobe.
- RD_DONE:
  - Data_valid=1 for exactly this cycle.
  - Next state is RD_HOLD if OE=0 and CE=0, else IDLE.
- RD_HOLD:
  - Data_out is held and the array is not re-read; address changes are ignored.
  - Return to IDLE when OE=1 or CE=1.
- WR_WAIT:
  - Requires CE=0 and WE=0 each cycle.
  - At counter 0, commit latched Data_in to the enabled lanes only, then go to WR_HOLD.
  - UB=LB=1 still completes the cycle with no array change.
- WR_HOLD:
  - Exactly one commit per WE-low burst; no re-commit while WE stays low.
  - Return to IDLE when WE=1 or CE=1.
- Abort:
  - In RD_WAIT/WR_WAIT, strobe release (CE=1, or OE=1 during a read, or WE=1 during a write) goes to IDLE.
  - No commit, no Data_valid, Data_out unchanged.
- Read-to-write switch: WE going low while in RD_WAIT/RD_HOLD aborts the read and goes to IDLE; the write starts on the following sample.
- Init_WE in any state other than IDLE, or while an access request is present, is ignored.
- Address wrap: ADDR bits above ADDR_W-1 are discarded, e.g. 16'h0400 aliases 16'h0000 for ADDR_W=10.
- Data_out changes only on read completion or reset.

Test Plan:
- Preload then read: Init 16'h1234 at addr 3. Hold CE=0, OE=0, ADDR=3, UB=LB=0 for 2 cycles with READ_LAT=1 -> Data_out=16'h1234 one edge after the first sample; Data_valid pulses once; Busy high throughout.
- Byte-masked write: array[5]=16'hFFFF, write 16'hA55A with UB=1, LB=0, WE low 2 cycles -> array[5]=16'hFF5A. Holding WE low 5 more cycles causes no second commit.
- Abort: READ_LAT=3, OE low 2 cycles then high -> no Data_valid, Data_out keeps prior value, state IDLE.
- Priority and wrap: OE=0 and WE=0 together, ADDR=16'h0407, Data_in=16'h0BEE -> write commits to array[7]; a later read of addr 7 returns 16'h0BEE.
- Reset mid-write: WRITE_LAT=4, assert Reset in cycle 2 of WE low -> array unchanged; outputs 0, Busy=0 immediately, asynchronously.
- Init blocked: Init_WE=1 during RD_HOLD -> target word unchanged. The same Init in IDLE with CE=1 -> written.
